truth_table_sweeper: RTL and testbench

- Sequential harness stage wrapped around a 4-input combinational function block. Upstream, it drives the function's `w` input through every code from 0 to 2^WIDTH-1.
- Downstream, it samples the function's single-bit output `f` after a programmable settle time, assembles the full truth table and compares it against an expected table.
- Lets the lab combinational blocks be exercised and self-checked in hardware or simulation without a hand-written stimulus list.

---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_if.sv | 38 +++
 rtl/truth_table_sweeper_mismatch_prio_enc.sv | 30 +++
 rtl/truth_table_sweeper.sv | 139 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// =============================================================================
// truth_table_sweeper_pkg : shared state encoding and default sizing
// Rev 1.0
// =============================================================================
`default_nettype none

package truth_table_sweeper_pkg;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
// =============================================================================
// truth_table_sweeper_if : stimulus/response bundle between sweeper and harness
// Rev 1.0
// =============================================================================
`default_nettype none

interface truth_table_sweeper_if
  import truth_table_sweeper_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                    start;
  logic [(1<<WIDTH)-1:0]   expected;
  logic                    f_in;
  logic [WIDTH-1:0]        w_out;
  logic                    busy;
  logic                    done;
  logic [(1<<WIDTH)-1:0]   table_out;
  logic [WIDTH:0]          ones_count;
  logic                    pass;
  logic [WIDTH-1:0]        first_fail;

  // Sweeper side
  modport slave (
    input  start, expected, f_in,
    output w_out, busy, done, table_out, ones_count, pass, first_fail
  );

  // Harness side
  modport master (
    output start, expected, f_in,
    input  w_out, busy, done, table_out, ones_count, pass, first_fail
  );

endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper_mismatch_prio_enc.sv
// =============================================================================
// mismatch_prio_enc : lowest-set-bit index of a mismatch vector plus any flag
// Rev 1.0
// =============================================================================
`default_nettype none

module mismatch_prio_enc
  import truth_table_sweeper_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic [(1<<WIDTH)-1:0] diff,
  output logic      [WIDTH-1:0]      idx,
  output logic                       any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |diff;
    for (int i = (1 << WIDTH) - 1; i >= 0; i--) begin
      if (diff[i]) begin
        idx = WIDTH'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// =============================================================================
// truth_table_sweeper : drives w through all codes, captures f, checks vs golden
// Rev 1.0
// =============================================================================
`default_nettype none

module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int c_num = 1 << WIDTH;
  localparam int c_cw  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_cw-1:0] c_load = c_cw'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      w_q, w_d;
  logic [c_cw-1:0]       cnt_q, cnt_d;
  logic [c_num-1:0]      exp_q, exp_d;
  logic [c_num-1:0]      table_q, table_d;
  logic [WIDTH:0]        ones_q, ones_d;
  logic                  pass_q, pass_d;
  logic [WIDTH-1:0]      ff_q, ff_d;

  logic [c_num-1:0]      w_cap;
  logic [WIDTH-1:0]      w_idx;
  logic                  w_any;

  // Table as it will look after the current SAMPLE edge; the verdict is
  // computed from this so pass/first_fail are valid on entry to DONE.
  always_comb begin
    w_cap        = table_q;
    w_cap[w_q]   = bus.f_in;
  end

  mismatch_prio_enc #(
    .WIDTH (WIDTH)
  ) u_prio_enc (
    .diff (w_cap ^ exp_q),
    .idx  (w_idx),
    .any  (w_any)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    ones_d  = ones_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          table_d = '0;
          ones_d  = '0;
          pass_d  = 1'b0;
          ff_d    = '0;
          exp_d   = bus.expected;
          w_d     = '0;
          if (SETTLE == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = c_load;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - c_cw'(1);
        end
      end
      ST_SAMPLE: begin
        table_d = w_cap;
        ones_d  = ones_q + {{WIDTH{1'b0}}, bus.f_in};
        if (w_q == {WIDTH{1'b1}}) begin
          state_d = ST_DONE;
          pass_d  = ~w_any;
          ff_d    = w_idx;
        end else begin
          w_d = w_q + WIDTH'(1);
          if (SETTLE != 0) begin
            state_d = ST_SETTLE;
            cnt_d   = c_load;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.w_out      = w_q;
  assign bus.busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.pass       = pass_q;
  assign bus.first_fail = ff_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// =============================================================================
// tb_truth_table_sweeper : vector table, random sweeps vs model, corner sequences
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic [15:0] func0;
  int          n_pass;
  int          n_total;

  truth_table_sweeper_if #(.WIDTH(4)) if0 ();
  truth_table_sweeper_if #(.WIDTH(4)) if1 ();

  truth_table_sweeper #(.WIDTH(4), .SETTLE(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  truth_table_sweeper #(.WIDTH(4), .SETTLE(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // Function blocks under test: dut0 sees an arbitrary truth table, dut1 sees w[3].
  assign if0.f_in = func0[if0.w_out];
  assign if1.f_in = if1.w_out[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fn;
    logic [15:0] exp;
    logic [15:0] tbl;
    int          ones;
    bit          pass;
    int          ff;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
  endtask

  // Reference: the captured table is the function itself; verdict from rules.
  task automatic model(input logic [15:0] fn, input logic [15:0] exp, output vec_t r);
    r.fn   = fn;
    r.exp  = exp;
    r.tbl  = fn;
    r.ones = 0;
    for (int i = 0; i < 16; i++) r.ones += int'(fn[i]);
    r.pass = (fn == exp);
    r.ff   = 0;
    for (int i = 0; i < 16; i++) begin
      if (fn[i] != exp[i]) begin
        r.ff = i;
        break;
      end
    end
  endtask

  // One sweep on dut0; optional mid-sweep start pulse and expected change.
  task automatic do_sweep(input string nm, input vec_t v, input bit disturb);
    int lat;
    int busy_n;
    int hold[16];
    bit hold_ok;
    for (int i = 0; i < 16; i++) hold[i] = 0;
    @(negedge clk);
    func0        = v.fn;
    if0.expected = v.exp;
    if0.start    = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    lat    = 1;
    busy_n = 0;
    if (if0.busy) begin
      busy_n++;
      hold[if0.w_out]++;
    end
    while (!if0.done && lat < 200) begin
      if (disturb && lat == 10) begin
        if0.start    = 1'b1;
        if0.expected = ~v.exp;
      end else if (disturb && lat == 11) begin
        if0.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (if0.busy) begin
        busy_n++;
        hold[if0.w_out]++;
      end
    end
    if0.start = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 16; i++) if (hold[i] != 2) hold_ok = 1'b0;
    chk({nm, " latency"},    lat, 33);
    chk({nm, " busy_cyc"},   busy_n, 32);
    chk({nm, " w_hold"},     {31'd0, hold_ok}, 32'd1);
    chk({nm, " table_out"},  {16'd0, if0.table_out}, {16'd0, v.tbl});
    chk({nm, " ones_count"}, {27'd0, if0.ones_count}, v.ones);
    chk({nm, " pass"},       {31'd0, if0.pass}, {31'd0, v.pass});
    chk({nm, " first_fail"}, {28'd0, if0.first_fail}, v.ff);
    @(posedge clk);
    #1;
    chk({nm, " done_drop"},  {31'd0, if0.done}, 32'd0);
    chk({nm, " hold_table"}, {16'd0, if0.table_out}, {16'd0, v.tbl});
  endtask

  vec_t vecs[6];

  initial begin
    vec_t r;
    int   cyc;
    int   t1;
    int   t2;
    int   nd;
    int   lat;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    func0   = 16'h0000;
    if0.start    = 1'b0;
    if0.expected = 16'h0000;
    if1.start    = 1'b0;
    if1.expected = 16'h0000;

    vecs[0] = '{fn: 16'hAAAA, exp: 16'hAAAA, tbl: 16'hAAAA, ones: 8,  pass: 1'b1, ff: 0};
    vecs[1] = '{fn: 16'h8000, exp: 16'h8001, tbl: 16'h8000, ones: 1,  pass: 1'b0, ff: 0};
    vecs[2] = '{fn: 16'hFFFF, exp: 16'hFFFF, tbl: 16'hFFFF, ones: 16, pass: 1'b1, ff: 0};
    vecs[3] = '{fn: 16'h00F0, exp: 16'h0070, tbl: 16'h00F0, ones: 4,  pass: 1'b0, ff: 7};
    vecs[4] = '{fn: 16'h0000, exp: 16'h0000, tbl: 16'h0000, ones: 0,  pass: 1'b1, ff: 0};
    vecs[5] = '{fn: 16'h1234, exp: 16'h1236, tbl: 16'h1234, ones: 5,  pass: 1'b0, ff: 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset dut0", {if0.w_out, if0.busy, if0.done, if0.table_out, if0.ones_count,
                       if0.pass, if0.first_fail}, 32'd0);
    chk("reset dut1", {if1.w_out, if1.busy, if1.done, if1.table_out, if1.ones_count,
                       if1.pass, if1.first_fail}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_sweep($sformatf("vec%0d", i), vecs[i], (i == 3));
    end

    for (int i = 0; i < 12; i++) begin
      logic [15:0] fn;
      logic [15:0] ex;
      fn = 16'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? fn : 16'($urandom);
      model(fn, ex, r);
      do_sweep($sformatf("rnd%0d", i), r, 1'b1);
    end

    // Reset in the middle of a sweep.
    @(negedge clk);
    func0        = 16'h5A5A;
    if0.expected = 16'h5A5A;
    if0.start    = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    cyc = 0;
    while (if0.w_out != 4'd7 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach w7", {31'd0, (cyc < 100)}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", {if0.w_out, if0.busy, if0.done, if0.table_out, if0.ones_count,
                        if0.pass, if0.first_fail}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (if0.done) nd++;
    end
    chk("no done after reset", nd, 0);
    model(16'h5A5A, 16'h5A5A, r);
    do_sweep("post_reset", r, 1'b0);

    // Start held high: two back-to-back sweeps, expected changed at cycle 10.
    @(negedge clk);
    func0        = 16'hAAAA;
    if0.expected = 16'hAAAA;
    if0.start    = 1'b1;
    cyc = 0;
    t1  = 0;
    t2  = 0;
    while (t2 == 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 10) if0.expected = 16'h0000;
      if (if0.done) begin
        if (t1 == 0) begin
          t1 = cyc;
          chk("b2b first pass", {31'd0, if0.pass}, 32'd1);
          chk("b2b first table", {16'd0, if0.table_out}, 32'h0000AAAA);
        end else begin
          t2 = cyc;
          if0.start = 1'b0;
          chk("b2b second pass", {31'd0, if0.pass}, 32'd0);
          chk("b2b second ff", {28'd0, if0.first_fail}, 32'd1);
        end
      end
    end
    if0.start = 1'b0;
    chk("b2b first latency", t1, 33);
    chk("b2b period", t2 - t1, 34);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b stopped", {31'd0, if0.busy}, 32'd0);

    // Zero-settle build.
    @(negedge clk);
    if1.expected = 16'hFF00;
    if1.start    = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    lat = 1;
    while (!if1.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s0 latency", lat, 17);
    chk("s0 table", {16'd0, if1.table_out}, 32'h0000FF00);
    chk("s0 ones", {27'd0, if1.ones_count}, 32'd8);
    chk("s0 pass", {31'd0, if1.pass}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
